axi_write_response_tracker: RTL

AXI_WRITE_RESPONSE_TRACKER -- requirements
Module: axi_write_response_tracker

---
 rtl/axi_write_response_tracker_if.sv | 37 +++
 rtl/axi_write_response_tracker.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/axi_write_response_tracker_if.sv
// Write-issue / B-channel bundle shared by a write master and the response tracker.
//   issue        : an AW handshake happened this cycle (master -> tracker)
//   issue_ready  : the tracker allows another write to be issued (tracker -> master)
//   bid/bresp/buser/bvalid : B-channel response payload and valid (master side -> tracker)
//   bready       : tracker accepts a B response this cycle (tracker -> master side)
interface axi_write_response_tracker_if #(
    parameter int AXI_BID_WIDTH   = 1,
    parameter int AXI_BUSER_WIDTH = 1
);
    logic                       issue;
    logic                       issue_ready;
    logic [AXI_BID_WIDTH-1:0]   bid;
    logic [1:0]                 bresp;
    logic [AXI_BUSER_WIDTH-1:0] buser;
    logic                       bvalid;
    logic                       bready;

    modport master (
        output issue,
        input  issue_ready,
        output bid,
        output bresp,
        output buser,
        output bvalid,
        input  bready
    );

    modport slave (
        input  issue,
        output issue_ready,
        input  bid,
        input  bresp,
        input  buser,
        input  bvalid,
        output bready
    );
endinterface

// File: rtl/axi_write_response_tracker.sv
// Tracks un-responded AXI writes, throttles new issues, records B-channel errors
// and supports a drain/resume handshake.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   bus            : issue/issue_ready and B-channel (slave side of the interface)
//   outstanding    : number of writes issued but not yet responded
//   resp_done      : one-cycle pulse the cycle after every accepted response
//   err_sticky     : an error response was accepted since the last err_clear
//   err_id/resp    : bid/bresp of the first such error
//   err_count      : saturating count of error responses
//   err_clear      : clears all error state (wins over a coincident error)
//   drain, resume  : enter drain mode / leave the drained state
//   drained        : drain finished, nothing outstanding
module axi_write_response_tracker #(
    parameter int AXI_BID_WIDTH   = 1,
    parameter int AXI_BUSER_WIDTH = 1,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    axi_write_response_tracker_if.slave          bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 resp_done,
    output logic                                 err_sticky,
    output logic [AXI_BID_WIDTH-1:0]             err_id,
    output logic [1:0]                           err_resp,
    output logic [7:0]                           err_count,
    input  logic                                 err_clear,
    input  logic                                 drain,
    input  logic                                 resume,
    output logic                                 drained
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } state_t;

    state_t                     state_reg;
    logic                       drained_reg;
    logic [CW-1:0]              outstanding_reg;
    logic [CW-1:0]              outstanding_next;
    logic                       resp_done_reg;
    logic                       err_sticky_reg;
    logic [AXI_BID_WIDTH-1:0]   err_id_reg;
    logic [1:0]                 err_resp_reg;
    logic [7:0]                 err_count_reg;

    logic issue_accept;
    logic b_accept;
    logic err_accept;

    // buser carries no meaning for tracking; folded here so it is visibly consumed.
    logic unused_buser;
    assign unused_buser = ^bus.buser;

    // Both handshake qualifiers depend only on registered state, never on the
    // incoming valids, so there is no combinational loop through the master.
    assign bus.bready      = (outstanding_reg != '0);
    assign bus.issue_ready = (state_reg == RUN) && (outstanding_reg < CW'(MAX_OUTSTANDING));

    assign issue_accept = bus.issue  && bus.issue_ready;
    assign b_accept     = bus.bvalid && bus.bready;
    assign err_accept   = b_accept && bus.bresp[1];

    always_comb begin
        outstanding_next = outstanding_reg;
        if (issue_accept && !b_accept) begin
            outstanding_next = outstanding_reg + CW'(1);
        end else if (b_accept && !issue_accept) begin
            outstanding_next = outstanding_reg - CW'(1);
        end
    end

    // Drain state machine; drained is registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= RUN;
            drained_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (drain) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Looking at the next count lets the final response of the
                    // drain complete it in the same cycle it is accepted.
                    if (outstanding_next == '0) begin
                        state_reg   <= DRAINED;
                        drained_reg <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (resume) begin
                        state_reg   <= RUN;
                        drained_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= RUN;
                    drained_reg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding_reg <= '0;
            resp_done_reg   <= 1'b0;
        end else begin
            outstanding_reg <= outstanding_next;
            resp_done_reg   <= b_accept;
        end
    end

    // Error bookkeeping; a clear in the same cycle as an error suppresses it.
    always_ff @(posedge clock) begin
        if (reset || err_clear) begin
            err_sticky_reg <= 1'b0;
            err_id_reg     <= '0;
            err_resp_reg   <= 2'b00;
            err_count_reg  <= 8'd0;
        end else if (err_accept) begin
            err_sticky_reg <= 1'b1;
            if (!err_sticky_reg) begin
                err_id_reg   <= bus.bid;
                err_resp_reg <= bus.bresp;
            end
            if (err_count_reg != 8'hFF) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
        end
    end

    assign outstanding = outstanding_reg;
    assign resp_done   = resp_done_reg;
    assign err_sticky  = err_sticky_reg;
    assign err_id      = err_id_reg;
    assign err_resp    = err_resp_reg;
    assign err_count   = err_count_reg;
    assign drained     = drained_reg;
endmodule
